// File: rtl/msg_pkg.sv
`default_nettype none
// ==========================================================================
// Module : msg_pkg
// Brief  : Marker/flag codes and framer state encoding shared by all framers.
// Rev    : 1.0
// ==========================================================================
package msg_pkg;

  localparam logic [7:0] MARKER_MASTER        = 8'h7E;
  localparam logic [7:0] FLAG_BOARD_TIME_CODE = 8'h54;
  localparam logic [7:0] FLAG_TELEMETRY       = 8'h55;
  localparam logic [7:0] FLAG_STATUS          = 8'h56;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Index width for an n-entry select; never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_det.sv
`default_nettype none
// ==========================================================================
// Module : edge_det
// Brief  : Single-bit rise/fall detector against a registered copy of i_d.
// Rev    : 1.0
// ==========================================================================
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_d;

  always_ff @(posedge clk) begin
    if (rst) r_d <= 1'b0;
    else     r_d <= i_d;
  end

  assign o_rise = i_d & ~r_d;
  assign o_fall = ~i_d & r_d;

endmodule
`default_nettype wire

// File: rtl/msg_framer.sv
`default_nettype none
// ==========================================================================
// Module : msg_framer
// Brief  : Frames a latched payload as MARKER, FLAG, LEN, payload, [CSUM].
// Rev    : 1.0
// ==========================================================================
module msg_framer
  import msg_pkg::*;
#(
  parameter int unsigned PL_BYTES = 5,
  parameter logic [7:0]  FLAG     = FLAG_BOARD_TIME_CODE,
  parameter logic [7:0]  MARKER   = MARKER_MASTER,
  parameter bit          CSUM_EN  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic [8*PL_BYTES-1:0] pl,
  input  logic                  tx_en,
  input  logic                  cd_busy,
  output logic [7:0]            q,
  output logic                  q_rdy,
  output logic                  msg_end,
  output logic                  busy,
  output logic                  ovf
);

  localparam int unsigned      c_CW       = $clog2(PL_BYTES + 6);
  localparam int unsigned      c_PW       = idx_width(PL_BYTES);
  localparam int unsigned      c_CS       = CSUM_EN ? 1 : 0;
  localparam logic [15:0]      c_LEN      = 16'(PL_BYTES + c_CS);
  localparam logic [c_CW-1:0]  c_LAST     = c_CW'(3 + PL_BYTES + c_CS);
  localparam logic [c_CW-1:0]  c_PAY_LAST = c_CW'(3 + PL_BYTES);

  state_t                     r_state, w_state_nx;
  logic [c_CW-1:0]            r_idx, w_idx_nx;
  logic [7:0]                 r_q, w_q_nx;
  logic [7:0]                 r_csum, w_csum_nx;
  logic                       r_pend, w_pend_nx;
  logic                       r_msg_end, w_msg_end_nx;
  logic                       r_ovf, w_ovf_nx;
  logic [PL_BYTES-1:0][7:0]   r_shadow;
  logic [PL_BYTES-1:0][7:0]   r_work;

  logic                       w_rise, w_fall, w_start;
  logic [c_PW-1:0]            w_pidx;
  logic [7:0]                 w_pay, w_byte;

  edge_det u_cd_edge (
    .clk    (clk),
    .rst    (rst),
    .i_d    (cd_busy),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_start = (r_state == ST_IDLE) & tx_en & r_pend;

  // Byte 0 of the payload sits in the top lane of the working register.
  always_comb begin
    w_pidx = c_PW'(w_idx_nx - c_CW'(4));
    w_pay  = r_work[c_PW'(PL_BYTES - 1) - w_pidx];
    case (w_idx_nx)
      c_CW'(0): w_byte = MARKER;
      c_CW'(1): w_byte = FLAG;
      c_CW'(2): w_byte = c_LEN[15:8];
      c_CW'(3): w_byte = c_LEN[7:0];
      default:  w_byte = (w_idx_nx <= c_PAY_LAST) ? w_pay : r_csum;
    endcase
  end

  always_comb begin
    w_state_nx   = r_state;
    w_idx_nx     = r_idx;
    w_csum_nx    = r_csum;
    w_msg_end_nx = 1'b0;
    w_ovf_nx     = ld & r_pend & ~w_start;
    w_pend_nx    = ld | (r_pend & ~w_start);

    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nx = ST_ISSUE;
          w_idx_nx   = '0;
          w_csum_nx  = '0;
        end
      end
      ST_ISSUE: begin
        if (!tx_en) begin
          w_state_nx = ST_IDLE;
          w_idx_nx   = '0;
        end else if (w_rise) begin
          w_state_nx = ST_HOLD;
          if ((r_idx != '0) && (r_idx <= c_PAY_LAST)) w_csum_nx = r_csum + r_q;
        end
      end
      ST_HOLD: begin
        // HOLD is only entered on a rise, so the first low sample is a fall.
        if (!tx_en) begin
          w_state_nx = ST_IDLE;
          w_idx_nx   = '0;
        end else if (w_fall) begin
          if (r_idx == c_LAST) begin
            w_state_nx   = ST_IDLE;
            w_idx_nx     = '0;
            w_msg_end_nx = 1'b1;
          end else begin
            w_state_nx = ST_ISSUE;
            w_idx_nx   = r_idx + c_CW'(1);
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_idx_nx   = '0;
      end
    endcase

    if (w_state_nx == ST_IDLE)
      w_q_nx = 8'h00;
    else if ((w_state_nx == ST_ISSUE) && (r_state != ST_ISSUE))
      w_q_nx = w_byte;
    else
      w_q_nx = r_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_q       <= 8'h00;
      r_csum    <= 8'h00;
      r_pend    <= 1'b0;
      r_msg_end <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_idx     <= w_idx_nx;
      r_q       <= w_q_nx;
      r_csum    <= w_csum_nx;
      r_pend    <= w_pend_nx;
      r_msg_end <= w_msg_end_nx;
      r_ovf     <= w_ovf_nx;
    end
  end

  // Payload registers carry no reset; pending alone says whether they matter.
  always_ff @(posedge clk) begin
    if (ld)      r_shadow <= pl;
    if (w_start) r_work   <= r_shadow;
  end

  assign q       = r_q;
  assign q_rdy   = (r_state == ST_ISSUE);
  assign busy    = (r_state != ST_IDLE);
  assign msg_end = r_msg_end;
  assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_msg_framer.sv
`default_nettype none
// ==========================================================================
// Module : tb_msg_framer
// Brief  : Directed checks of msg_framer for 5-byte, 5-byte+CSUM and 300-byte builds.
// Rev    : 1.0
// ==========================================================================
module tb_msg_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, tx_en;
  logic          ld_a, ld_b, ld_c;
  logic [39:0]   pl_a, pl_b;
  logic [2399:0] pl_c;
  logic          cd_a, cd_b, cd_c;
  logic [7:0]    q_a, q_b, q_c;
  logic          q_rdy_a, q_rdy_b, q_rdy_c;
  logic          msg_end_a, msg_end_b, msg_end_c;
  logic          busy_a, busy_b, busy_c;
  logic          ovf_a, ovf_b, ovf_c;

  int n_vec = 0;
  int n_err = 0;
  int mend_a = 0, mend_b = 0, mend_c = 0, ovfc_a = 0;
  int cnt_a = 0, cnt_b = 0, cnt_c = 0;
  logic [7:0] got_a[$], got_b[$], got_c[$];

  msg_framer #(.PL_BYTES(5), .CSUM_EN(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .ld(ld_a), .pl(pl_a), .tx_en(tx_en), .cd_busy(cd_a),
    .q(q_a), .q_rdy(q_rdy_a), .msg_end(msg_end_a), .busy(busy_a), .ovf(ovf_a));

  msg_framer #(.PL_BYTES(5), .CSUM_EN(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .ld(ld_b), .pl(pl_b), .tx_en(tx_en), .cd_busy(cd_b),
    .q(q_b), .q_rdy(q_rdy_b), .msg_end(msg_end_b), .busy(busy_b), .ovf(ovf_b));

  msg_framer #(.PL_BYTES(300), .CSUM_EN(1'b0)) u_dut_c (
    .clk(clk), .rst(rst), .ld(ld_c), .pl(pl_c), .tx_en(tx_en), .cd_busy(cd_c),
    .q(q_c), .q_rdy(q_rdy_c), .msg_end(msg_end_c), .busy(busy_c), .ovf(ovf_c));

  // Coder models: accept an offered byte, hold cd_busy high for 3 cycles.
  initial begin
    cd_a = 1'b0;
    forever begin
      @(negedge clk);
      if (cnt_a > 0) begin
        cnt_a--;
        if (cnt_a == 0) cd_a = 1'b0;
      end else if (q_rdy_a && !cd_a) begin
        cd_a = 1'b1; cnt_a = 3; got_a.push_back(q_a);
      end
    end
  end

  initial begin
    cd_b = 1'b0;
    forever begin
      @(negedge clk);
      if (cnt_b > 0) begin
        cnt_b--;
        if (cnt_b == 0) cd_b = 1'b0;
      end else if (q_rdy_b && !cd_b) begin
        cd_b = 1'b1; cnt_b = 3; got_b.push_back(q_b);
      end
    end
  end

  initial begin
    cd_c = 1'b0;
    forever begin
      @(negedge clk);
      if (cnt_c > 0) begin
        cnt_c--;
        if (cnt_c == 0) cd_c = 1'b0;
      end else if (q_rdy_c && !cd_c) begin
        cd_c = 1'b1; cnt_c = 3; got_c.push_back(q_c);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (msg_end_a === 1'b1) mend_a++;
      if (msg_end_b === 1'b1) mend_b++;
      if (msg_end_c === 1'b1) mend_c++;
      if (ovf_a === 1'b1)     ovfc_a++;
    end
  end

  task automatic pulse_ld_a(input logic [39:0] p);
    pl_a = p; ld_a = 1'b1;
    @(negedge clk);
    ld_a = 1'b0;
  endtask

  task automatic wait_mend_a(input int want, input int limit);
    for (int c = 0; c < limit && mend_a < want; c++) @(negedge clk);
    n_vec++;
    if (mend_a < want) begin
      n_err++; $display("FAIL wait_msg_end_a: got %0d msg_end, want %0d", mend_a, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_en = 1'b0; ld_a = 1'b0; ld_b = 1'b0; ld_c = 1'b0;
    pl_a = '0; pl_b = '0; pl_c = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (q_a !== 8'h00)    begin n_err++; $display("FAIL reset_q: got %h want 00", q_a); end
    n_vec++; if (q_rdy_a !== 1'b0) begin n_err++; $display("FAIL reset_q_rdy: got %b want 0", q_rdy_a); end
    n_vec++; if (msg_end_a !== 1'b0) begin n_err++; $display("FAIL reset_msg_end: got %b want 0", msg_end_a); end
    n_vec++; if (busy_a !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_vec++; if (ovf_a !== 1'b0)   begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf_a); end
    tx_en = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_no_pending_a: busy %b want 0", busy_a); end
    n_vec++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL reset_no_pending_b: busy %b want 0", busy_b); end
    n_vec++; if (busy_c !== 1'b0) begin n_err++; $display("FAIL reset_no_pending_c: busy %b want 0", busy_c); end
  endtask

  task automatic test_frame();
    logic [7:0] exp [9];
    exp = '{8'h7E, 8'h54, 8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    got_a.delete(); mend_a = 0; ovfc_a = 0;
    pl_a = 40'h0102030405; ld_a = 1'b1;
    @(negedge clk);
    ld_a = 1'b0;
    n_vec++; if (q_rdy_a !== 1'b0) begin n_err++; $display("FAIL frame_lat_t: q_rdy %b want 0", q_rdy_a); end
    @(negedge clk);
    n_vec++; if (q_rdy_a !== 1'b1) begin n_err++; $display("FAIL frame_lat_t1: q_rdy %b want 1", q_rdy_a); end
    n_vec++; if (q_a !== 8'h7E)    begin n_err++; $display("FAIL frame_first_q: got %h want 7e", q_a); end
    wait_mend_a(1, 200);
    repeat (3) @(negedge clk);
    n_vec++; if (mend_a !== 1) begin n_err++; $display("FAIL frame_msg_end_count: got %0d want 1", mend_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL frame_busy_after: got %b want 0", busy_a); end
    n_vec++; if (got_a.size() !== 9) begin n_err++; $display("FAIL frame_len: got %0d want 9", got_a.size()); end
    for (int k = 0; k < 9; k++) begin
      n_vec++;
      if (k >= got_a.size() || got_a[k] !== exp[k]) begin
        n_err++; $display("FAIL frame_byte%0d: got %h want %h", k, (k < got_a.size()) ? got_a[k] : 8'hxx, exp[k]);
      end
    end
    n_vec++; if (ovfc_a !== 0) begin n_err++; $display("FAIL frame_no_ovf: got %0d want 0", ovfc_a); end
  endtask

  task automatic test_csum();
    logic [7:0] exp [10];
    exp = '{8'h7E, 8'h54, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h69};
    got_b.delete(); mend_b = 0;
    pl_b = 40'h0102030405; ld_b = 1'b1;
    @(negedge clk);
    ld_b = 1'b0;
    for (int c = 0; c < 200 && mend_b < 1; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_vec++; if (mend_b !== 1) begin n_err++; $display("FAIL csum_msg_end_count: got %0d want 1", mend_b); end
    n_vec++; if (got_b.size() !== 10) begin n_err++; $display("FAIL csum_len: got %0d want 10", got_b.size()); end
    for (int k = 0; k < 10; k++) begin
      n_vec++;
      if (k >= got_b.size() || got_b[k] !== exp[k]) begin
        n_err++; $display("FAIL csum_byte%0d: got %h want %h", k, (k < got_b.size()) ? got_b[k] : 8'hxx, exp[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] p1, p2;
    p1 = 40'hC1C2C3C4C5; p2 = 40'hD1D2D3D4D5;
    got_a.delete(); mend_a = 0; ovfc_a = 0;
    pulse_ld_a(p1);
    pulse_ld_a(p2);
    wait_mend_a(2, 400);
    repeat (3) @(negedge clk);
    n_vec++; if (ovfc_a !== 0) begin n_err++; $display("FAIL b2b_no_ovf: got %0d want 0", ovfc_a); end
    n_vec++; if (got_a.size() !== 18) begin n_err++; $display("FAIL b2b_len: got %0d want 18", got_a.size()); end
    n_vec++; if (got_a.size() > 9 && got_a[9] !== 8'h7E) begin n_err++; $display("FAIL b2b_marker2: got %h want 7e", got_a[9]); end
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (got_a.size() < 18 || got_a[4+k] !== p1[39-8*k -: 8] || got_a[13+k] !== p2[39-8*k -: 8]) begin
        n_err++; $display("FAIL b2b_payload%0d: got %h/%h want %h/%h", k,
          (got_a.size() >= 18) ? got_a[4+k] : 8'hxx, (got_a.size() >= 18) ? got_a[13+k] : 8'hxx,
          p1[39-8*k -: 8], p2[39-8*k -: 8]);
      end
    end
  endtask

  task automatic test_ovf();
    logic [39:0] p1, p2, p3;
    p1 = 40'h1122334455; p2 = 40'hAABBCCDDEE; p3 = 40'h6162636465;
    got_a.delete(); mend_a = 0; ovfc_a = 0;
    pulse_ld_a(p1);
    repeat (3) @(negedge clk);
    pulse_ld_a(p2);
    repeat (2) @(negedge clk);
    n_vec++; if (ovfc_a !== 0) begin n_err++; $display("FAIL ovf_after_first: got %0d want 0", ovfc_a); end
    pulse_ld_a(p3);
    @(negedge clk);
    n_vec++; if (ovfc_a !== 1) begin n_err++; $display("FAIL ovf_pulse: got %0d want 1", ovfc_a); end
    wait_mend_a(2, 400);
    repeat (3) @(negedge clk);
    n_vec++; if (ovfc_a !== 1) begin n_err++; $display("FAIL ovf_total: got %0d want 1", ovfc_a); end
    n_vec++; if (got_a.size() !== 18) begin n_err++; $display("FAIL ovf_len: got %0d want 18", got_a.size()); end
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (got_a.size() < 18 || got_a[4+k] !== p1[39-8*k -: 8] || got_a[13+k] !== p3[39-8*k -: 8]) begin
        n_err++; $display("FAIL ovf_payload%0d: got %h/%h want %h/%h", k,
          (got_a.size() >= 18) ? got_a[4+k] : 8'hxx, (got_a.size() >= 18) ? got_a[13+k] : 8'hxx,
          p1[39-8*k -: 8], p3[39-8*k -: 8]);
      end
    end
  endtask

  task automatic test_abort();
    logic [39:0] p2;
    p2 = 40'h2122232425;
    got_a.delete(); mend_a = 0;
    pulse_ld_a(40'h0A0B0C0D0E);
    for (int c = 0; c < 200 && got_a.size() < 7; c++) @(negedge clk);
    n_vec++; if (got_a.size() < 7) begin n_err++; $display("FAIL abort_reach_byte6: got %0d bytes want 7", got_a.size()); end
    @(negedge clk);
    tx_en = 1'b0;
    @(negedge clk);
    n_vec++; if (busy_a !== 1'b0)  begin n_err++; $display("FAIL abort_busy: got %b want 0", busy_a); end
    n_vec++; if (q_a !== 8'h00)    begin n_err++; $display("FAIL abort_q: got %h want 00", q_a); end
    n_vec++; if (q_rdy_a !== 1'b0) begin n_err++; $display("FAIL abort_q_rdy: got %b want 0", q_rdy_a); end
    pulse_ld_a(p2);
    repeat (6) @(negedge clk);
    n_vec++; if (mend_a !== 0)     begin n_err++; $display("FAIL abort_no_msg_end: got %0d want 0", mend_a); end
    n_vec++; if (busy_a !== 1'b0)  begin n_err++; $display("FAIL abort_hold_idle: got %b want 0", busy_a); end
    got_a.delete();
    tx_en = 1'b1;
    wait_mend_a(1, 200);
    repeat (2) @(negedge clk);
    n_vec++; if (got_a.size() !== 9) begin n_err++; $display("FAIL abort_restart_len: got %0d want 9", got_a.size()); end
    n_vec++; if (got_a.size() > 0 && got_a[0] !== 8'h7E) begin n_err++; $display("FAIL abort_restart_marker: got %h want 7e", got_a[0]); end
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (got_a.size() < 9 || got_a[4+k] !== p2[39-8*k -: 8]) begin
        n_err++; $display("FAIL abort_restart_pl%0d: got %h want %h", k,
          (got_a.size() >= 9) ? got_a[4+k] : 8'hxx, p2[39-8*k -: 8]);
      end
    end
  endtask

  task automatic test_rst_hold();
    logic [39:0] p;
    p = 40'h3132333435;
    got_a.delete(); mend_a = 0; ovfc_a = 0;
    pulse_ld_a(40'h9192939495);
    for (int c = 0; c < 100 && got_a.size() < 3; c++) @(negedge clk);
    @(negedge clk);
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy: got %b want 1", busy_a); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (q_a !== 8'h00)       begin n_err++; $display("FAIL rst_q: got %h want 00", q_a); end
    n_vec++; if (q_rdy_a !== 1'b0)    begin n_err++; $display("FAIL rst_q_rdy: got %b want 0", q_rdy_a); end
    n_vec++; if (busy_a !== 1'b0)     begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    n_vec++; if (msg_end_a !== 1'b0)  begin n_err++; $display("FAIL rst_msg_end: got %b want 0", msg_end_a); end
    repeat (6) @(negedge clk);
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL rst_pending_cleared: busy %b want 0", busy_a); end
    got_a.delete(); mend_a = 0;
    pulse_ld_a(p);
    wait_mend_a(1, 200);
    repeat (2) @(negedge clk);
    n_vec++; if (got_a.size() !== 9) begin n_err++; $display("FAIL rst_frame_len: got %0d want 9", got_a.size()); end
    n_vec++; if (got_a.size() > 3 && got_a[3] !== 8'h05) begin n_err++; $display("FAIL rst_frame_len_lo: got %h want 05", got_a[3]); end
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (got_a.size() < 9 || got_a[4+k] !== p[39-8*k -: 8]) begin
        n_err++; $display("FAIL rst_frame_pl%0d: got %h want %h", k,
          (got_a.size() >= 9) ? got_a[4+k] : 8'hxx, p[39-8*k -: 8]);
      end
    end
  endtask

  task automatic test_large();
    logic [7:0] e;
    got_c.delete(); mend_c = 0;
    for (int k = 0; k < 300; k++) pl_c[2399-8*k -: 8] = 8'((k * 7 + 3) & 255);
    ld_c = 1'b1;
    @(negedge clk);
    ld_c = 1'b0;
    for (int c = 0; c < 3000 && mend_c < 1; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_vec++; if (mend_c !== 1) begin n_err++; $display("FAIL large_msg_end: got %0d want 1", mend_c); end
    n_vec++; if (got_c.size() !== 304) begin n_err++; $display("FAIL large_len: got %0d want 304", got_c.size()); end
    for (int k = 0; k < 304; k++) begin
      case (k)
        0:       e = 8'h7E;
        1:       e = 8'h54;
        2:       e = 8'h01;
        3:       e = 8'h2C;
        default: e = 8'(((k - 4) * 7 + 3) & 255);
      endcase
      n_vec++;
      if (k >= got_c.size() || got_c[k] !== e) begin
        n_err++; $display("FAIL large_byte%0d: got %h want %h", k, (k < got_c.size()) ? got_c[k] : 8'hxx, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_csum();
    test_back_to_back();
    test_ovf();
    test_abort();
    test_rst_hold();
    test_large();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
